mult_acc_drain: RTL
===================

MULT_ACC_DRAIN -- requirements
Module: mult_acc_drain

Interface
REQ-001: The block SHALL take its product width from the `MAX_PRECISION define; P2 = 2*`MAX_PRECISION.
REQ-002: Parameter FIFO_DEPTH, default 4, SHALL set the product input buffer depth (power of two, >=2).
REQ-003: Parameter ACC_GUARD, default 8, SHALL set the accumulator guard bits; AW = P2+ACC_GUARD.
REQ-004: clk  input  1  single clock; all state updates on its rising edge.
REQ-005: rst_n  input  1  asynchronous active-low reset.
REQ-006: en  input  1  clock enable; low holds every register, including the FIFO.
REQ-007: precision  input  6  operand precision of incoming products (4, 8, 16, 32).
REQ-008: prod_in  input  P2  signed product from the upstream multiplier.
REQ-009: prod_valid  input  1  prod_in is valid this cycle; driven by the multiplier's ready output.
REQ-010: acc_len  input  8  products per accumulated sum.
REQ-011: stall  output  1  back-pressure to the operand feeder.
REQ-012: out_sum  output  AW  signed accumulated result.
REQ-013: out_valid  output  1  out_sum is valid.
REQ-014: out_ready  input  1  downstream accepts out_sum.
REQ-015: ovf_err  output  1  sticky flag set when a product is dropped.

Function
REQ-016: Push: with en high, prod_valid high at a rising edge SHALL write prod_in into the FIFO.
REQ-017: Full FIFO, no same-edge pop: the product SHALL be dropped and ovf_err set until reset.
REQ-018: Full FIFO with a same-edge pop: the push SHALL be accepted.
REQ-019: stall SHALL be combinationally high when FIFO occupancy >= FIFO_DEPTH-1.
REQ-020: Pop: the FIFO SHALL pop only when it is non-empty and state is IDLE or ACCUM.
REQ-021: Popped value SHALL be sign-extended from bit 2*precision-1 to AW; precision values other than 4/8/16/32 SHALL be treated as `MAX_PRECISION.
REQ-022: States SHALL be IDLE, ACCUM and HOLD; reset state is IDLE.
REQ-023: IDLE pop: acc_len SHALL be latched (0 treated as 1), acc <= ext(product), cnt <= 1.
REQ-024: IDLE pop with latched length 1: next state HOLD and out_sum <= ext(product); otherwise next state ACCUM.
REQ-025: ACCUM pop: acc <= acc + ext(product), cnt <= cnt + 1.
REQ-026: ACCUM pop where cnt+1 equals the latched length: out_sum <= acc + ext(product) and next state HOLD.
REQ-027: ACCUM with an empty FIFO SHALL hold state, acc and cnt.
REQ-028: HOLD: out_valid SHALL be high and out_sum stable until an edge where out_ready is high; that edge returns the state to IDLE.
REQ-029: HOLD: no pop SHALL occur; pushes continue per REQ-016..REQ-018.
REQ-030: out_valid SHALL be registered and high exactly in HOLD.
REQ-031: Latency: a product pushed at edge k SHALL be popped no earlier than edge k+1, so out_valid rises no earlier than after edge k+1.
REQ-032: Accumulation SHALL wrap in two's complement at AW bits; the default guard covers 255 full-scale products without wrap.
REQ-033: Changes to acc_len mid-group SHALL NOT affect the current group.
REQ-034: Changes to precision SHALL apply per popped product.

Reset
REQ-035: Reset assertion SHALL immediately clear the FIFO, cnt, acc, out_sum, out_valid and ovf_err to 0 and force IDLE, including mid-group.
REQ-036: During reset, stall SHALL read 0.
REQ-037: After reset deassertion, the first edge with en high and prod_valid high SHALL be a normal push.

Verification
REQ-038: acc_len=3, precision=16, products 5, -2, 7 on consecutive cycles, out_ready=1 -> one out_valid pulse with out_sum=10, then IDLE.
REQ-039: acc_len=0, single product -9 -> out_sum=-9 after 2 edges; treated as length 1.
REQ-040: precision=4, prod_in=8'hF0 -> sign-extended to -16; acc_len=2 with second product 8'h10 -> out_sum=0.
REQ-041: out_ready=0 held for 10 cycles while 6 products arrive, FIFO_DEPTH=4 -> stall high at occupancy 3; 2 products dropped; ovf_err=1; out_sum unchanged.
REQ-042: rst_n pulsed low mid-ACCUM with cnt=2 -> all outputs 0 immediately; a next group of 2 products 1, 1 -> out_sum=2.
REQ-043: en=0 for 5 cycles mid-group with prod_valid high -> no push and no state change; resuming en yields the correct sum.

Source files
------------

// File: rtl/mult_acc_drain.sv
// Product accumulator: buffers signed products in a small FIFO, sums groups of
// acc_len sign-extended products and presents each sum under a valid/ready hold.
`ifndef MAX_PRECISION
`define MAX_PRECISION 32
`endif

module mult_acc_drain #(
    parameter int FIFO_DEPTH = 4,
    parameter int ACC_GUARD  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    en,
    input  logic [5:0]                              precision,
    input  logic [2*`MAX_PRECISION-1:0]             prod_in,
    input  logic                                    prod_valid,
    input  logic [7:0]                              acc_len,
    output logic                                    stall,
    output logic [2*`MAX_PRECISION+ACC_GUARD-1:0]   out_sum,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    ovf_err
);

    localparam int P2 = 2 * `MAX_PRECISION;
    localparam int AW = P2 + ACC_GUARD;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // state | meaning
    // IDLE  | waiting for the first product of a group
    // ACCUM | summing products until the latched length is reached
    // HOLD  | out_sum presented with out_valid, waiting for out_ready
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [P2-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [PW:0]     count_q, count_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [AW-1:0]   sum_q, sum_d;
    logic [AW-1:0]   acc_plus;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      len_new;
    logic            valid_q, valid_d;
    logic            ovf_q, ovf_d;

    logic            empty, full, pop, push, drop;
    logic [P2-1:0]   head;
    logic [7:0]      width_bits, shamt;
    logic signed [P2-1:0] head_sh;
    logic [AW-1:0]   head_ext;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PW+1)'(FIFO_DEPTH));
    assign pop   = en && !empty && ((state_q == IDLE) || (state_q == ACCUM));
    assign push  = en && prod_valid && (!full || pop);
    assign drop  = en && prod_valid && full && !pop;
    assign stall = rst_n && (count_q >= (PW+1)'(FIFO_DEPTH - 1));

    // Sign bit sits at 2*precision-1; shift it to the top, then arithmetic-shift back.
    always_comb begin
        head       = mem_q[rd_ptr_q];
        width_bits = 8'(P2);
        case (precision)
            6'd4, 6'd8, 6'd16, 6'd32: begin
                if ({2'b00, precision} <= 8'(`MAX_PRECISION))
                    width_bits = {1'b0, precision, 1'b0};
            end
            default: width_bits = 8'(P2);
        endcase
        shamt    = 8'(P2) - width_bits;
        head_sh  = $signed(head << shamt) >>> shamt;
        head_ext = {{ACC_GUARD{head_sh[P2-1]}}, head_sh};
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        ovf_d    = ovf_q || drop;
        count_d  = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        acc_plus = acc_q + head_ext;
        len_new  = (acc_len == 8'd0) ? 8'd1 : acc_len;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        len_d = len_new;
                        acc_d = head_ext;
                        cnt_d = 8'd1;
                        if (len_new == 8'd1) begin
                            state_d = HOLD;
                            sum_d   = head_ext;
                        end else begin
                            state_d = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (pop) begin
                        acc_d = acc_plus;
                        cnt_d = cnt_q + 8'd1;
                        if (({1'b0, cnt_q} + 9'd1) == {1'b0, len_q}) begin
                            state_d = HOLD;
                            sum_d   = acc_plus;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            len_q    <= 8'd1;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= prod_in;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    assign out_sum   = sum_q;
    assign out_valid = valid_q;
    assign ovf_err   = ovf_q;

endmodule
